// File: rtl/sc_datamem_io.sv
// Data memory plus memory-mapped I/O for the single-cycle CPU: sub-word RAM stores,
// 32-bit output registers, synchronised input ports and a sticky input-change status.

module sc_datamem_in_lane #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic         changed
);
    logic [W-1:0] sync1, sync2, prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync    = sync2;
    assign changed = (sync2 != prev);
endmodule

module sc_datamem_io #(
    parameter int DMEM_WORDS_LOG2 = 5,
    parameter int IO_BIT          = 7,
    parameter int NUM_OUT         = 3,
    parameter int NUM_IN          = 2,
    parameter int IN_W            = 5
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [31:0]             addr,
    input  logic [31:0]             datain,
    input  logic                    we,
    input  logic [1:0]              size,
    output logic [31:0]             dataout,
    output logic [31:0]             mem_dataout,
    output logic [31:0]             io_read_data,
    output logic [NUM_OUT*32-1:0]   out_port,
    input  logic [NUM_IN*IN_W-1:0]  in_port,
    output logic                    io_event
);
    localparam int DEPTH = 1 << DMEM_WORDS_LOG2;

    logic [DMEM_WORDS_LOG2-1:0]       ram_idx;
    logic [4:0]                       k;
    logic                             is_io, ram_we, io_we;
    logic [3:0]                       be;
    logic [31:0]                      wdata;
    logic [31:0]                      mem [DEPTH];
    logic [NUM_OUT-1:0][31:0]         out_reg;
    logic [NUM_IN-1:0][IN_W-1:0]      in_sync;
    logic [NUM_IN-1:0]                changed, status, clr;
    logic                             unused_addr;

    assign ram_idx     = addr[DMEM_WORDS_LOG2+1:2];
    assign k           = addr[6:2];
    assign is_io       = addr[IO_BIT];
    assign ram_we      = we & ~is_io;
    assign io_we       = we & is_io;
    assign unused_addr = ^addr;

    // Sub-word stores replicate the datum across lanes and let the byte enables pick.
    always_comb begin
        be    = 4'b1111;
        wdata = datain;
        case (size)
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{datain[15:0]}};
            end
            2'b10: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{datain[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign mem_dataout = mem[ram_idx];

    for (genvar j = 0; j < NUM_IN; j++) begin : g_in
        sc_datamem_in_lane #(.W(IN_W)) u_lane (
            .clock   (clock),
            .resetn  (resetn),
            .din     (in_port[IN_W*j +: IN_W]),
            .sync    (in_sync[j]),
            .changed (changed[j])
        );
    end

    assign clr = (io_we && k == 5'd31) ? datain[NUM_IN-1:0] : '0;

    // Set is OR'd in after the clear mask so a same-cycle change survives a clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_reg <= '0;
            status  <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++)
                if (io_we && k == 5'(i)) out_reg[i] <= datain;
            status <= (status & ~clr) | changed;
        end
    end

    always_comb begin
        io_read_data = '0;
        for (int i = 0; i < NUM_OUT; i++)
            if (k == 5'(i)) io_read_data = out_reg[i];
        for (int j = 0; j < NUM_IN; j++)
            if (k == 5'(16 + j)) io_read_data = 32'(in_sync[j]);
        if (k == 5'd31) io_read_data = 32'(status);
    end

    assign dataout  = is_io ? io_read_data : mem_dataout;
    assign out_port = out_reg;
    assign io_event = |status;
endmodule

// File: tb/tb_sc_datamem_io.sv
// Directed bench for sc_datamem_io at default parameters (3 outputs, 2 x 5-bit inputs).

module tb_sc_datamem_io;
    logic        clock, resetn;
    logic [31:0] addr, datain;
    logic        we;
    logic [1:0]  size;
    logic [31:0] dataout, mem_dataout, io_read_data;
    logic [95:0] out_port;
    logic [9:0]  in_port;
    logic        io_event;

    int n_cmp = 0;
    int n_err = 0;

    sc_datamem_io dut (
        .clock        (clock),
        .resetn       (resetn),
        .addr         (addr),
        .datain       (datain),
        .we           (we),
        .size         (size),
        .dataout      (dataout),
        .mem_dataout  (mem_dataout),
        .io_read_data (io_read_data),
        .out_port     (out_port),
        .in_port      (in_port),
        .io_event     (io_event)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Called 1 time unit after a rising edge; returns 1 unit after the committing edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr = a; datain = d; size = sz; we = 1'b1;
        @(posedge clock); #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 0; we = 0; addr = 32'hFC; datain = 0; size = 0;
        in_port = 10'h3FF;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (out_port !== 96'h0) begin n_err++; $display("FAIL reset_out_port got %h exp 0", out_port); end
        n_cmp++; if (io_event !== 1'b0) begin n_err++; $display("FAIL reset_io_event got %b exp 0", io_event); end
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL reset_status got %h exp 0", dataout); end
        in_port = 10'h0;
        @(posedge clock); #1;
        resetn = 1;
        repeat (4) @(posedge clock);
        #1;
        n_cmp++; if (io_event !== 1'b0) begin n_err++; $display("FAIL post_reset_io_event got %b exp 0", io_event); end
    endtask

    task automatic test_ram_subword();
        store(32'h10, 32'h11223344, 2'b00);
        store(32'h12, 32'h000000AA, 2'b10);
        store(32'h10, 32'h0000BEEF, 2'b01);
        addr = 32'h10; #1;
        n_cmp++; if (dataout !== 32'h11AABEEF) begin n_err++; $display("FAIL ram_subword got %h exp 11aabeef", dataout); end
        n_cmp++; if (mem_dataout !== 32'h11AABEEF) begin n_err++; $display("FAIL ram_mem_dataout got %h exp 11aabeef", mem_dataout); end
        n_cmp++; if (out_port !== 96'h0) begin n_err++; $display("FAIL ram_no_io got %h exp 0", out_port); end
        store(32'h14, 32'hFFFFFFFF, 2'b11);
        store(32'h16, 32'h00001234, 2'b01);
        store(32'h17, 32'h00000056, 2'b10);
        store(32'h14, 32'h000000C3, 2'b10);
        addr = 32'h14; #1;
        n_cmp++; if (dataout !== 32'h5634FFC3) begin n_err++; $display("FAIL ram_upper_half_byte got %h exp 5634ffc3", dataout); end
    endtask

    task automatic test_out_ports();
        store(32'h04, 32'h01020304, 2'b00);
        addr = 32'h84; datain = 32'hDEADBEEF; size = 2'b10; we = 1'b1;
        #1;
        n_cmp++; if (out_port !== 96'h0) begin n_err++; $display("FAIL out_before_edge got %h exp 0", out_port); end
        @(posedge clock); #1;
        we = 1'b0;
        n_cmp++; if (out_port !== {32'h0, 32'hDEADBEEF, 32'h0}) begin n_err++; $display("FAIL out_port1 got %h exp 0_deadbeef_0", out_port); end
        n_cmp++; if (dataout !== 32'hDEADBEEF) begin n_err++; $display("FAIL out_readback got %h exp deadbeef", dataout); end
        n_cmp++; if (mem_dataout !== 32'h01020304) begin n_err++; $display("FAIL out_ram_untouched got %h exp 01020304", mem_dataout); end
        addr = 32'h04; #1;
        n_cmp++; if (dataout !== 32'h01020304) begin n_err++; $display("FAIL out_ram_load got %h exp 01020304", dataout); end
    endtask

    task automatic test_input_sync();
        addr = 32'hC0;
        in_port = {5'h00, 5'h13};
        @(posedge clock); #1;
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL in_edge1 got %h exp 0", dataout); end
        @(posedge clock); #1;
        n_cmp++; if (dataout !== 32'h13) begin n_err++; $display("FAIL in_edge2 got %h exp 13", dataout); end
        n_cmp++; if (io_event !== 1'b0) begin n_err++; $display("FAIL in_event_edge2 got %b exp 0", io_event); end
        @(posedge clock); #1;
        addr = 32'hFC; #1;
        n_cmp++; if (io_event !== 1'b1) begin n_err++; $display("FAIL in_event_edge3 got %b exp 1", io_event); end
        n_cmp++; if (dataout !== 32'h1) begin n_err++; $display("FAIL in_status_edge3 got %h exp 1", dataout); end
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (dataout !== 32'h1) begin n_err++; $display("FAIL in_status_hold got %h exp 1", dataout); end
        addr = 32'hC4; #1;
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL in_port1 got %h exp 0", dataout); end
    endtask

    task automatic test_clear_collision();
        in_port = {5'h00, 5'h07};
        @(posedge clock); #1;
        @(posedge clock); #1;
        store(32'hFC, 32'h1, 2'b00);
        addr = 32'hFC; #1;
        n_cmp++; if (dataout !== 32'h1) begin n_err++; $display("FAIL clr_collision got %h exp 1", dataout); end
        store(32'hFC, 32'h1, 2'b00);
        addr = 32'hFC; #1;
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL clr_plain got %h exp 0", dataout); end
        n_cmp++; if (io_event !== 1'b0) begin n_err++; $display("FAIL clr_io_event got %b exp 0", io_event); end
        in_port = {5'h1F, 5'h08};
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (dataout !== 32'h3) begin n_err++; $display("FAIL clr_both_set got %h exp 3", dataout); end
        store(32'hFC, 32'h2, 2'b00);
        addr = 32'hFC; #1;
        n_cmp++; if (dataout !== 32'h1) begin n_err++; $display("FAIL clr_mask got %h exp 1", dataout); end
        n_cmp++; if (io_event !== 1'b1) begin n_err++; $display("FAIL clr_mask_event got %b exp 1", io_event); end
        store(32'hFC, 32'h1, 2'b00);
        addr = 32'hFC; #1;
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL clr_final got %h exp 0", dataout); end
    endtask

    task automatic test_unmapped_alias();
        store(32'h20, 32'h55AA55AA, 2'b00);
        store(32'hA0, 32'h12345678, 2'b00);
        store(32'hC0, 32'hFFFFFFFF, 2'b00);
        addr = 32'hA0; #1;
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h exp 0", dataout); end
        n_cmp++; if (mem_dataout !== 32'h55AA55AA) begin n_err++; $display("FAIL unmapped_raw_ram got %h exp 55aa55aa", mem_dataout); end
        n_cmp++; if (out_port !== {32'h0, 32'hDEADBEEF, 32'h0}) begin n_err++; $display("FAIL unmapped_out got %h exp 0_deadbeef_0", out_port); end
        addr = 32'hC0; #1;
        n_cmp++; if (dataout !== 32'h08) begin n_err++; $display("FAIL input_store_ignored got %h exp 08", dataout); end
        store(32'h7C, 32'hCAFEF00D, 2'b00);
        addr = 32'h17C; #1;
        n_cmp++; if (dataout !== 32'hCAFEF00D) begin n_err++; $display("FAIL alias_17c got %h exp cafef00d", dataout); end
        store(32'h00, 32'h0BADCAFE, 2'b00);
        addr = 32'h100; #1;
        n_cmp++; if (dataout !== 32'h0BADCAFE) begin n_err++; $display("FAIL alias_100 got %h exp 0badcafe", dataout); end
        addr = 32'hFFFFFF7C; #1;
        n_cmp++; if (dataout !== 32'hCAFEF00D) begin n_err++; $display("FAIL alias_high got %h exp cafef00d", dataout); end
    endtask

    initial begin
        test_reset();
        test_ram_subword();
        test_out_ports();
        test_input_sync();
        test_clear_collision();
        test_unmapped_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
